// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared IF/ID payload type, bubble constant and skid-stage state encoding
package mips_pipe_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
  // Encoded as {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} skid_state_e;
endpackage

// File: rtl/skid_slot.sv
// skid_slot: one pipeline slot (valid bit plus if_id_t payload) with load/clear and async active-low reset
module skid_slot
  import mips_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clr,
  input  if_id_t d,
  output logic   v,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else begin
      v <= clr ? 1'b0 : (load ? 1'b1 : v);
      if (load) q <= d;
    end
endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF->ID register with 2-entry skid buffer, flush and registered in_ready.
// Optional back-pressure counter stall_cnt when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = MIPS_NOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  logic main_v, skid_v, main_load, main_clr, skid_load, skid_clr, accept, drain;
  if_id_t in_d, main_d, main_q, skid_q;
  skid_state_e state, next_state;
  assign in_d      = '{pc: in_pc, instr: in_instr};
  assign state     = skid_state_e'({main_v, skid_v});
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;
  assign main_load = !flush & ((!main_v & accept) | (drain & (skid_v | accept)));
  assign main_clr  = flush | (drain & !skid_v & !accept);
  assign skid_load = !flush & (state == ONE) & accept & !drain;
  assign skid_clr  = flush | (skid_v & drain);
  // On a drain the skid entry always refills main first, keeping FIFO order.
  assign main_d    = skid_v ? skid_q : in_d;
  always_comb
    next_state = flush ? EMPTY :
                 (((state == FULL) & !drain) | skid_load) ? FULL :
                 (main_load | (main_v & !main_clr)) ? ONE : EMPTY;
  skid_slot u_main (.clk(clk), .rst(rst), .load(main_load), .clr(main_clr), .d(main_d), .v(main_v), .q(main_q));
  skid_slot u_skid (.clk(clk), .rst(rst), .load(skid_load), .clr(skid_clr), .d(in_d), .v(skid_v), .q(skid_q));
  always_ff @(posedge clk or negedge rst)
    if (!rst) in_ready <= 1'b1;
    else      in_ready <= next_state != FULL;
  assign out_valid = main_v;
  assign out_pc    = main_q.pc;
  assign out_instr = main_v ? main_q.instr : NOP_INSTR;
`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (main_v & !out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
`endif
  always_ff @(posedge clk)
    if (rst) assert (main_v || !skid_v) else $error("skid slot valid without main slot");
endmodule
